// File: rtl/core_pkg.sv
// core_pkg: shared funct3 encodings, mem/wb FSM states and byte-enable constants
package core_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [3:0] BE_B  = 4'b0001;
  localparam logic [3:0] BE_H  = 4'b0011;
  localparam logic [3:0] BE_W  = 4'b1111;
  typedef enum logic {IDLE, ACCESS} state_t;
endpackage

// File: rtl/load_align.sv
// load_align: selects the load lane from a bus word and sign/zero-extends it
module load_align
  import core_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  a,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);
  logic [31:0] bs;
  logic [31:0] hs;
  // halfword lane follows a[1] only; byte lane follows a[1:0]
  always_comb begin
    bs = rdata >> {a, 3'b000};
    hs = rdata >> {a[1], 4'b0000};
    data = funct3 == F3_B  ? {{24{bs[7]}}, bs[7:0]} :
           funct3 == F3_BU ? {24'b0, bs[7:0]} :
           funct3 == F3_H  ? {{16{hs[15]}}, hs[15:0]} :
           funct3 == F3_HU ? {16'b0, hs[15:0]} : rdata;
  end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: RV32I memory/writeback stage; MEM_MISALIGN_TRAP_EN adds a misalign trap output
module mem_wb_stage
  import core_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              cpu_clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [4:0]        ex_rd,
  input  logic [XLEN-1:0]   ex_alu,
  input  logic [XLEN-1:0]   ex_store_data,
  input  logic              ex_mem_rd,
  input  logic              ex_mem_wr,
  input  logic [2:0]        ex_funct3,
  input  logic              ex_reg_wr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic [XLEN-1:0]   wb,
  output logic [4:0]        rd,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic              misalign,
`endif
  output logic              wb_sig
);
  state_t            state_q;
  logic              consumed_q, req_q, we_q, wbs_q, regwr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q, be_d;
  logic [XLEN-1:0]   wdata_q, wdata_d, wb_q, ld;
  logic [4:0]        rd_q, rdl_q;
  logic [2:0]        f3_q;
  logic [1:0]        a_q;
  logic              accept, memop, mis, go;
`ifdef MEM_MISALIGN_TRAP_EN
  logic              mis_q;
  assign misalign = mis_q;
  assign mis = (ex_funct3[1:0] == 2'b01 && ex_alu[0]) || (ex_funct3[1:0] == 2'b10 && ex_alu[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign wb        = wb_q;
  assign rd        = rd_q;
  assign wb_sig    = wbs_q;
  load_align u_align (.rdata(mem_rdata), .a(a_q), .funct3(f3_q), .data(ld));
  // acceptance, stall and store lane placement for the instruction on the ex_* inputs
  always_comb begin
    accept  = state_q == IDLE && ex_valid && !consumed_q;
    memop   = ex_mem_rd || ex_mem_wr;
    go      = accept && memop && !mis;
    stall   = !rst && (state_q == ACCESS ? !mem_ack : go);
    be_d    = ex_funct3[1:0] == 2'b00 ? BE_B << ex_alu[1:0] :
              ex_funct3[1:0] == 2'b01 ? BE_H << {ex_alu[1], 1'b0} : BE_W;
    wdata_d = ex_funct3[1:0] == 2'b00 ? {4{ex_store_data[7:0]}} :
              ex_funct3[1:0] == 2'b01 ? {2{ex_store_data[15:0]}} : ex_store_data;
  end
  // IDLE/ACCESS sequencing; bus outputs stay frozen while ACCESS waits for the ack
  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      consumed_q <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      wb_q       <= '0;
      rd_q       <= '0;
      wbs_q      <= 1'b0;
      rdl_q      <= '0;
      f3_q       <= '0;
      a_q        <= '0;
      regwr_q    <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q      <= 1'b0;
`endif
    end else begin
      consumed_q <= 1'b0;
      wbs_q      <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q      <= accept && memop && mis;
`endif
      if (state_q == IDLE) begin
        if (accept && !memop) begin
          wb_q  <= ex_alu;
          rd_q  <= ex_rd;
          wbs_q <= ex_reg_wr;
        end else if (go) begin
          state_q <= ACCESS;
          req_q   <= 1'b1;
          we_q    <= ex_mem_wr && !ex_mem_rd;
          addr_q  <= {ex_alu[ADDR_W-1:2], 2'b00};
          be_q    <= be_d;
          wdata_q <= wdata_d;
          rdl_q   <= ex_rd;
          f3_q    <= ex_funct3;
          a_q     <= ex_alu[1:0];
          regwr_q <= ex_reg_wr;
        end
      end else if (mem_ack) begin
        state_q    <= IDLE;
        req_q      <= 1'b0;
        consumed_q <= 1'b1;
        if (!we_q) begin
          wb_q  <= ld;
          rd_q  <= rdl_q;
          wbs_q <= regwr_q && rdl_q != 5'd0;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed scoreboard bench for mem_wb_stage
module tb_mem_wb_stage;
  logic        cpu_clk = 1'b0, rst = 1'b1;
  logic        ex_valid = 1'b0, ex_mem_rd = 1'b0, ex_mem_wr = 1'b0, ex_reg_wr = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic [31:0] ex_alu = '0, ex_store_data = '0, mem_rdata = '0;
  logic [2:0]  ex_funct3 = '0;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_we, stall, wb_sig;
  logic [31:0] mem_addr, mem_wdata, wb;
  logic [3:0]  mem_be;
  logic [4:0]  rd;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign;
`endif
  int checks = 0, errors = 0;
  logic [36:0] sb[$];
  logic [36:0] e;

  always #5 cpu_clk = ~cpu_clk;

  mem_wb_stage dut (
    .cpu_clk(cpu_clk), .rst(rst), .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_alu(ex_alu),
    .ex_store_data(ex_store_data), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
    .ex_funct3(ex_funct3), .ex_reg_wr(ex_reg_wr), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .stall(stall), .wb(wb), .rd(rd),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign(misalign),
`endif
    .wb_sig(wb_sig)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge cpu_clk);
    #1;
    if (wb_sig) begin
      if (sb.size() == 0) chk("unexpected_wb_sig", 32'(wb_sig), 32'd0);
      else begin
        e = sb.pop_front();
        chk("wb", wb, e[31:0]);
        chk("rd", 32'(rd), 32'(e[36:32]));
      end
    end
  endtask

  task automatic drv(input logic v, input logic lr, input logic sw, input logic [2:0] f3,
                     input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] r, input logic rw);
    ex_valid = v; ex_mem_rd = lr; ex_mem_wr = sw; ex_funct3 = f3;
    ex_alu = alu; ex_store_data = sd; ex_rd = r; ex_reg_wr = rw;
    checks++;
    assert (!(v && lr && sw)) else begin
      errors++;
      $error("FAIL illegal_rd_wr: observed 1 expected 0");
    end
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask

  initial begin
    step(); step();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_be", 32'(mem_be), 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_wb", wb, 32'h0);
    chk("rst_rd", 32'(rd), 32'd0);
    chk("rst_wb_sig", 32'(wb_sig), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("rst_misalign", 32'(misalign), 32'd0);
`endif
    rst = 1'b0;
    step();
    drv(1'b1, 1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 5'd5, 1'b1);
    sb.push_back({5'd5, 32'h1234});
    #1 chk("alu_stall", 32'(stall), 32'd0);
    step();
    chk("alu_wb_sig", 32'(wb_sig), 32'd1);
    chk("alu_no_req", 32'(mem_req), 32'd0);
    idle();
    step();
    chk("alu_pulse", 32'(wb_sig), 32'd0);
    chk("alu_hold_wb", wb, 32'h1234);
    drv(1'b1, 1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 5'd7, 1'b1);
    sb.push_back({5'd7, 32'hFFFF_FF80});
    #1 chk("lb_stall_accept", 32'(stall), 32'd1);
    step();
    chk("lb_req", 32'(mem_req), 32'd1);
    chk("lb_we", 32'(mem_we), 32'd0);
    chk("lb_addr", mem_addr, 32'h100);
    chk("lb_be", 32'(mem_be), 32'b1000);
    chk("lb_stall_wait1", 32'(stall), 32'd1);
    step();
    chk("lb_stall_wait2", 32'(stall), 32'd1);
    chk("lb_addr_held", mem_addr, 32'h100);
    step();
    mem_ack = 1'b1; mem_rdata = 32'h80FF_0000;
    #1 chk("lb_stall_ack", 32'(stall), 32'd0);
    step();
    mem_ack = 1'b0;
    chk("lb_done_req", 32'(mem_req), 32'd0);
    chk("lb_wb_sig", 32'(wb_sig), 32'd1);
    chk("lb_consumed_stall", 32'(stall), 32'd0);
    step();
    chk("lb_not_reaccepted", 32'(mem_req), 32'd0);
    idle();
    step();
    drv(1'b1, 1'b1, 1'b0, 3'b101, 32'h202, 32'h0, 5'd8, 1'b1);
    sb.push_back({5'd8, 32'h0000_BEEF});
    step();
    chk("lhu_be", 32'(mem_be), 32'b1100);
    mem_ack = 1'b1; mem_rdata = 32'hBEEF_1234;
    step();
    mem_ack = 1'b0;
    idle();
    chk("lhu_wb_sig", 32'(wb_sig), 32'd1);
    step();
    drv(1'b1, 1'b0, 1'b1, 3'b001, 32'h302, 32'hAAAA_5678, 5'd0, 1'b0);
    step();
    chk("sh_we", 32'(mem_we), 32'd1);
    chk("sh_be", 32'(mem_be), 32'b1100);
    chk("sh_wdata", mem_wdata, 32'h5678_5678);
    chk("sh_addr", mem_addr, 32'h300);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    idle();
    chk("sh_no_wb", 32'(wb_sig), 32'd0);
    step();
    drv(1'b1, 1'b0, 1'b1, 3'b000, 32'h401, 32'h1234_56AB, 5'd0, 1'b0);
    step();
    chk("sb_be", 32'(mem_be), 32'b0010);
    chk("sb_wdata", mem_wdata, 32'hABAB_ABAB);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    idle();
    step();
    drv(1'b1, 1'b1, 1'b0, 3'b001, 32'h500, 32'h0, 5'd9, 1'b1);
    sb.push_back({5'd9, 32'hFFFF_8001});
    step();
    chk("lh_be", 32'(mem_be), 32'b0011);
    mem_ack = 1'b1; mem_rdata = 32'h0000_8001;
    step();
    mem_ack = 1'b0;
    idle();
    step();
    drv(1'b1, 1'b1, 1'b0, 3'b010, 32'h600, 32'h0, 5'd0, 1'b1);
    step();
    chk("lw_x0_be", 32'(mem_be), 32'b1111);
    mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
    step();
    mem_ack = 1'b0;
    idle();
    chk("lw_x0_no_wb", 32'(wb_sig), 32'd0);
    step();
    drv(1'b1, 1'b1, 1'b0, 3'b010, 32'h704, 32'h0, 5'd3, 1'b1);
    step();
    chk("rst_access_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    idle();
    step();
    rst = 1'b0;
    chk("rst_access_req_low", 32'(mem_req), 32'd0);
    chk("rst_access_stall", 32'(stall), 32'd0);
    chk("rst_access_wb_sig", 32'(wb_sig), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_ack = 1'b0;
    step();
    chk("late_ack_no_wb", 32'(wb_sig), 32'd0);
    chk("late_ack_no_req", 32'(mem_req), 32'd0);
`ifdef MEM_MISALIGN_TRAP_EN
    drv(1'b1, 1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 5'd4, 1'b1);
    #1 chk("mis_stall", 32'(stall), 32'd0);
    step();
    idle();
    chk("mis_pulse", 32'(misalign), 32'd1);
    chk("mis_no_req", 32'(mem_req), 32'd0);
    chk("mis_no_wb", 32'(wb_sig), 32'd0);
    step();
    chk("mis_pulse_end", 32'(misalign), 32'd0);
    chk("mis_still_no_req", 32'(mem_req), 32'd0);
`else
    drv(1'b1, 1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 5'd4, 1'b1);
    sb.push_back({5'd4, 32'h1122_3344});
    step();
    chk("lw_unaligned_addr", mem_addr, 32'h100);
    chk("lw_unaligned_be", 32'(mem_be), 32'b1111);
    mem_ack = 1'b1; mem_rdata = 32'h1122_3344;
    step();
    mem_ack = 1'b0;
    idle();
    chk("lw_unaligned_wb_sig", 32'(wb_sig), 32'd1);
`endif
    step(); step();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
